// File: rtl/pulsar_iter_pkg.sv
// pulsar_iter_pkg
// Shared definitions for the pulsar_iter_add block:
//   - state_t    : controller state encoding (IDLE, ITER, FIN), 2 bits
//   - DEF_WIDTH  : default data width
//   - DEF_CNT_W  : default iteration-count width
//   - DEF_STEP   : default per-iteration increment
package pulsar_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int          DEF_WIDTH = 64;
  localparam int          DEF_CNT_W = 8;
  localparam int unsigned DEF_STEP  = 1;

endpackage

// File: rtl/pulsar_iter_add_step.sv
// pulsar_step_add
// Combinational WIDTH-bit adder with carry-out.
// Ports:
//   a, b  : WIDTH-bit operands
//   sum   : a + b modulo 2^WIDTH
//   cout  : carry out of the top bit
module pulsar_step_add #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/pulsar_iter_add.sv
// pulsar_iter_add
// Iterative adder: starting from arg0, adds STEP once per clock for arg1
// iterations and presents the result with a one-cycle done pulse.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset
//   go    : start/hold request, held high by the caller until done
//   arg0  : initial value (sampled on the start edge)
//   arg1  : iteration count N (sampled on the start edge)
//   ret   : result, arg0 + N*STEP; valid together with done
//   done  : one-cycle completion pulse
//   busy  : high while an operation is in flight
//   ovf   : saturation flag for the current result
// Configuration:
//   PULSAR_ITER_SAT_EN : when defined, additions saturate at all-ones and
//                        ovf reports the saturation; otherwise additions
//                        wrap and ovf is tied low.
module pulsar_iter_add
  import pulsar_iter_pkg::*;
#(
  parameter int          WIDTH = DEF_WIDTH,
  parameter int          CNT_W = DEF_CNT_W,
  parameter int unsigned STEP  = DEF_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] arg0,
  input  logic [CNT_W-1:0] arg1,
  output logic [WIDTH-1:0] ret,
  output logic             done,
  output logic             busy,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  state_t           state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] ret_reg;

  logic [WIDTH-1:0] add_sum;
  logic             add_carry;
  logic [WIDTH-1:0] acc_next;

  pulsar_step_add #(
    .WIDTH (WIDTH)
  ) u_step_add (
    .a    (acc_reg),
    .b    (STEP_W),
    .sum  (add_sum),
    .cout (add_carry)
  );

`ifdef PULSAR_ITER_SAT_EN
  // sat_reg tracks saturation of the operation in flight; ovf_reg holds the
  // flag of the last completed operation alongside ret_reg.
  logic sat_reg;
  logic sat_next;
  logic ovf_reg;

  // Once saturated, acc stays pinned at all-ones for the rest of the run.
  always_comb begin
    acc_next = add_sum;
    sat_next = sat_reg;
    if (add_carry || sat_reg) begin
      acc_next = '1;
      sat_next = 1'b1;
    end
  end

  assign ovf = (state_reg == FIN) ? sat_reg : ovf_reg;
`else
  logic unused_carry;
  assign unused_carry = add_carry;
  assign acc_next     = add_sum;
  assign ovf          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ret_reg   <= '0;
`ifdef PULSAR_ITER_SAT_EN
      sat_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (go) begin
            acc_reg   <= arg0;
            cnt_reg   <= arg1;
`ifdef PULSAR_ITER_SAT_EN
            sat_reg   <= 1'b0;
`endif
            // A zero count skips straight to completion.
            state_reg <= (arg1 == '0) ? FIN : ITER;
          end
        end
        ITER: begin
          if (!go) begin
            // Abort: result registers are left untouched.
            state_reg <= IDLE;
          end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg - CNT_W'(1);
`ifdef PULSAR_ITER_SAT_EN
            sat_reg <= sat_next;
`endif
            // Leave on the last iteration so cnt never reaches 0 in ITER.
            if (cnt_reg == CNT_W'(1)) begin
              state_reg <= FIN;
            end
          end
        end
        FIN: begin
          ret_reg   <= acc_reg;
`ifdef PULSAR_ITER_SAT_EN
          ovf_reg   <= sat_reg;
`endif
          // Always return to IDLE; a held go restarts from there.
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign done = (state_reg == FIN);
  assign busy = (state_reg != IDLE);
  // The result is forwarded from acc during FIN so it is valid with done.
  assign ret  = (state_reg == FIN) ? acc_reg : ret_reg;

endmodule

// File: tb/tb_pulsar_iter_add.sv
// tb_pulsar_iter_add
// Scoreboard bench for pulsar_iter_add. Two instances: a 64-bit STEP=1 block
// and an 8-bit STEP=100 block (for wrap/saturation). Stimulus pushes the
// expected result and completion cycle; a monitor per instance pops and
// compares whenever done is seen.
module tb_pulsar_iter_add;

  typedef struct {
    logic [63:0] ret;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;

  logic        go = 1'b0;
  logic [63:0] arg0 = '0;
  logic [7:0]  arg1 = '0;
  logic [63:0] ret;
  logic        done, busy, ovf;

  logic        go8 = 1'b0;
  logic [7:0]  arg0_8 = '0;
  logic [7:0]  arg1_8 = '0;
  logic [7:0]  ret8;
  logic        done8, busy8, ovf8;

  int          checks = 0;
  int          failures = 0;
  exp_t        q64[$];
  exp_t        q8[$];
  logic [63:0] last_ret64 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulsar_iter_add #(.WIDTH(64), .CNT_W(8), .STEP(1)) dut (
    .clk(clk), .reset(reset), .go(go), .arg0(arg0), .arg1(arg1),
    .ret(ret), .done(done), .busy(busy), .ovf(ovf)
  );

  pulsar_iter_add #(.WIDTH(8), .CNT_W(8), .STEP(100)) dut8 (
    .clk(clk), .reset(reset), .go(go8), .arg0(arg0_8), .arg1(arg1_8),
    .ret(ret8), .done(done8), .busy(busy8), .ovf(ovf8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: arg0 + N*STEP, either wrapped or clamped at 2^WIDTH-1.
  function automatic exp_t model64(input logic [63:0] a, input int n);
    exp_t        e;
    logic [64:0] s;
    s = {1'b0, a} + 65'(n);
    e.cyc = 0;
`ifdef PULSAR_ITER_SAT_EN
    e.ret = s[64] ? {64{1'b1}} : s[63:0];
    e.ovf = s[64];
`else
    e.ret = s[63:0];
    e.ovf = 1'b0;
`endif
    return e;
  endfunction

  function automatic exp_t model8(input logic [7:0] a, input int n);
    exp_t e;
    int   s;
    s = int'(a) + n * 100;
    e.cyc = 0;
`ifdef PULSAR_ITER_SAT_EN
    e.ret = (s > 255) ? 64'd255 : 64'(s);
    e.ovf = (s > 255);
`else
    e.ret = 64'(s % 256);
    e.ovf = 1'b0;
`endif
    return e;
  endfunction

  // Monitors: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (q64.size() == 0) begin
        chk("unexpected_done64", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q64.pop_front();
        chk("ret64", ret, e.ret);
        chk("ovf64", 64'(ovf), 64'(e.ovf));
        chk("done_cycle64", 64'(cyc), 64'(e.cyc));
        $display("txn dut64 ret=%0h ovf=%b cycle=%0d", ret, ovf, cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("ret8", 64'(ret8), e.ret);
        chk("ovf8", 64'(ovf8), 64'(e.ovf));
        chk("done_cycle8", 64'(cyc), 64'(e.cyc));
        $display("txn dut8 ret=%0d ovf=%b cycle=%0d", ret8, ovf8, cyc);
      end
    end
  end

  // One complete operation with go held until done, then released.
  task automatic run_op(input bit sel, input logic [63:0] a, input int n);
    exp_t e;
    int   k;
    @(negedge clk);
    k = cyc;
    if (!sel) begin
      go = 1'b1; arg0 = a; arg1 = 8'(n);
      e = model64(a, n);
      e.cyc = k + n + 1;
      q64.push_back(e);
      last_ret64 = e.ret;
    end else begin
      go8 = 1'b1; arg0_8 = a[7:0]; arg1_8 = 8'(n);
      e = model8(a[7:0], n);
      e.cyc = k + n + 1;
      q8.push_back(e);
    end
    for (int i = 1; i <= n + 1; i++) begin
      @(negedge clk);
      chk("busy_run", 64'(sel ? busy8 : busy), 64'd1);
    end
    go = 1'b0;
    go8 = 1'b0;
    @(negedge clk);
    chk("busy_after", 64'(sel ? busy8 : busy), 64'd0);
  endtask

  initial begin
    exp_t e;
    int   k;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ret", ret, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_ret8", 64'(ret8), 64'd0);
    reset = 1'b0;

    // Directed: basic run, zero count, wrap/saturate on the 8-bit block.
    run_op(1'b0, 64'd5, 3);
    run_op(1'b0, 64'd7, 0);
    run_op(1'b1, 64'd200, 1);
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 5);
    run_op(1'b0, 64'd11, 2);

    // Abort: go dropped in cycle 4 of a 10-iteration run.
    @(negedge clk);
    k = cyc;
    go = 1'b1; arg0 = 64'd0; arg1 = 8'd10;
    repeat (4) @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_ret", ret, last_ret64);
    repeat (12) @(negedge clk);
    chk("abort_ret_hold", ret, last_ret64);

    // Reset in cycle 2 of a 5-iteration run.
    @(negedge clk);
    go = 1'b1; arg0 = 64'd42; arg1 = 8'd5;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    go = 1'b0;
    chk("rstrun_ret", ret, 64'd0);
    chk("rstrun_busy", 64'(busy), 64'd0);
    chk("rstrun_done", 64'(done), 64'd0);
    last_ret64 = '0;
    repeat (8) @(negedge clk);

    // Back-to-back: go held through done, second done 4 cycles later.
    @(negedge clk);
    k = cyc;
    go = 1'b1; arg0 = 64'd100; arg1 = 8'd2;
    e = model64(64'd100, 2); e.cyc = k + 3; q64.push_back(e);
    repeat (3) @(negedge clk);
    arg0 = 64'd300;
    e = model64(64'd300, 2); e.cyc = k + 7; q64.push_back(e);
    repeat (4) @(negedge clk);
    go = 1'b0;
    last_ret64 = e.ret;
    @(negedge clk);
    chk("b2b_busy", 64'(busy), 64'd0);
    chk("b2b_ret_hold", ret, last_ret64);

    // Randomized operations across both instances.
    for (int i = 0; i < 30; i++) begin
      logic [63:0] a;
      a = {$urandom(), $urandom()};
      if (($urandom() & 32'd7) == 0) a = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 4));
      run_op(1'($urandom_range(0, 1)), a, int'($urandom_range(0, 6)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("q64_drained", 64'(q64.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulsar_iter_add.md
PULSAR_ITER_ADD -- requirements
Module: pulsar_iter_add

Interface
REQ-001 Parameter WIDTH, default 64: data width of arg0, ret and the accumulator.
REQ-002 Parameter CNT_W, default 8: width of the runtime iteration count arg1.
REQ-003 Parameter STEP, default 1: constant added per iteration, truncated to WIDTH bits.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port go  input  1: start/hold request; the caller holds it high until it sees done.
REQ-007 Port arg0  input  WIDTH: initial value, sampled only on the start edge.
REQ-008 Port arg1  input  CNT_W: iteration count N, sampled only on the start edge.
REQ-009 Port ret  output  WIDTH: result register, arg0 + N*STEP.
REQ-010 Port done  output  1: one-cycle completion pulse.
REQ-011 Port busy  output  1: high while in ITER or FIN.
REQ-012 Port ovf  output  1: sticky saturation flag for the current result; see REQ-027.

Function
REQ-013 States SHALL be IDLE, ITER and FIN.
- IDLE to ITER: start edge (go=1) with arg1!=0.
- IDLE to FIN: start edge with arg1==0.
- ITER to FIN: cnt==1.
- FIN to IDLE: always.
REQ-014 Start edge SHALL load acc<=arg0 and cnt<=arg1.
REQ-015 Each ITER edge SHALL perform acc<=acc+STEP and cnt<=cnt-1.
REQ-016 FIN SHALL drive done=1 for exactly one cycle and load ret<=acc on the edge leaving FIN.
- ret SHALL also present acc combinationally while in FIN, so the result is valid in the same cycle as done.
REQ-017 Latency: with go sampled in cycle 0, done SHALL be high in cycle N+1 (N=0 gives cycle 1).
REQ-018 ret SHALL hold its value in IDLE until the next successful completion.
REQ-019 go=0 while in ITER SHALL abort the operation.
- Next state IDLE; no done pulse; ret and ovf unchanged.
REQ-020 go remaining high through FIN SHALL NOT restart the block in FIN.
- The block returns to IDLE.
- A new start occurs in the following cycle if go is still 1.
REQ-021 Without saturation, addition SHALL wrap modulo 2^WIDTH.
REQ-022 The counter SHALL never underflow: cnt==0 is never entered in ITER.
REQ-023 busy SHALL equal (state!=IDLE); done SHALL equal (state==FIN).

Reset
REQ-024 reset=1 SHALL force, on the next edge:
- state=IDLE;
- acc, cnt, ret = 0;
- ovf=0;
- done=0 and busy=0.
REQ-025 Reset SHALL take priority over go and over any operation in progress.
- No done pulse is produced for an interrupted operation.

Configuration
REQ-026 Macro PULSAR_ITER_SAT_EN SHALL select saturating arithmetic.
REQ-027 With PULSAR_ITER_SAT_EN defined:
- an ITER add whose carry-out is 1 SHALL set acc to all-ones and set an internal sticky flag;
- later adds keep acc at all-ones;
- ovf SHALL present the flag while in FIN and hold it with ret after completion;
- the flag clears on the next start edge.
REQ-028 Without PULSAR_ITER_SAT_EN: wrapping arithmetic and ovf tied to 0.

Structure
REQ-029 Package pulsar_iter_pkg SHALL hold:
- the state enum typedef (IDLE, ITER, FIN; 2-bit encoding);
- the default parameter constants.
REQ-030 Sub-module pulsar_step_add SHALL implement the combinational WIDTH-bit adder.
- It outputs sum and carry-out.
- It is instanced once for acc+STEP.

Verification
REQ-031 WIDTH=64, STEP=1: arg0=5, arg1=3, go held -> done in cycle 4, ret=8, ovf=0.
REQ-032 arg0=7, arg1=0 -> done in cycle 1, ret=7; busy high only in cycle 1.
REQ-033 arg0=0, arg1=10; go dropped in cycle 4 -> no done, ret keeps its prior value, IDLE next cycle.
REQ-034 WIDTH=8, STEP=100, arg0=200, arg1=1:
- without macro -> ret=44 (wrapped), ovf=0;
- with macro -> ret=255, ovf=1.
REQ-035 reset asserted in cycle 2 of an arg1=5 run -> ret=0, done never pulses, busy=0 after the reset edge.
REQ-036 Back-to-back: go held through done with arg1=2 -> second done 4 cycles after the first, ret updated each time.
